// File: rtl/dsp_pkg.sv
// Shared width helpers for FIFO pointers, addresses and occupancy counts.
// Widths derive from DEPTH so every user agrees on pointer layout.
package dsp_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra MSB acts as the wrap bit that separates full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, read either registered or
// combinational. Only the read register is reset, never the array.
module sync_fifo_ram
    import dsp_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int DEPTH    = 32,
    parameter int ASYNC_RD = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [addr_w(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      re,
    input  logic [addr_w(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = (ASYNC_RD != 0) ? mem[raddr] : rdata_q;

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with wrap-bit pointers, threshold flags, sticky
// overflow/underflow, flush, and optional first-word-fall-through.
module sync_fifo_ext
    import dsp_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int DEPTH    = 32,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ptr_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;
    logic          empty_w, full_w;
    logic [WIDTH-1:0] ram_rdata;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A read never frees space for a same-cycle write, nor vice versa.
    assign wr_acc = wr_en && !full_w && !flush;
    assign rd_acc = rd_en && !empty_w && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
            count_d    = wr_ptr_d - rd_ptr_d;
            rd_valid_d = rd_acc;
            ovf_d      = ovf_q || (wr_en && full_w);
            udf_d      = udf_q || (rd_en && empty_w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ASYNC_RD (FWFT)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    // FWFT masks the unwritten head word so reset and empty read as zero.
    assign rd_valid     = (FWFT != 0) ? !empty_w : rd_valid_q;
    assign rd_data      = ((FWFT != 0) && empty_w) ? '0 : ram_rdata;
    assign full         = full_w;
    assign empty        = empty_w;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_L);
    assign almost_empty = (count_q <= AE_L);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench: registered-read instance plus a FWFT instance, DEPTH=8.
module tb_sync_fifo_ext;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        wr_en;
    logic [17:0] wr_data;
    logic        rd_en;
    logic [17:0] rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        overflow, underflow;

    logic        f_wr_en;
    logic [17:0] f_wr_data;
    logic        f_rd_en;
    logic [17:0] f_rd_data;
    logic        f_rd_valid, f_full, f_empty, f_af, f_ae;
    logic [3:0]  f_count;
    logic        f_ovf, f_udf;

    int tests;
    int fails;

    sync_fifo_ext #(
        .WIDTH(18), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ext #(
        .WIDTH(18), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut_f (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " count"}, 32'(count), 0);
        check({tag, " empty"}, 32'(empty), 1);
        check({tag, " full"}, 32'(full), 0);
        check({tag, " ae"}, 32'(almost_empty), 1);
        check({tag, " af"}, 32'(almost_full), 0);
        check({tag, " rd_valid"}, 32'(rd_valid), 0);
        check({tag, " ovf"}, 32'(overflow), 0);
        check({tag, " udf"}, 32'(underflow), 0);
        check({tag, " rd_data"}, 32'(rd_data), 0);
        check({tag, " f rd_valid"}, 32'(f_rd_valid), 0);
        check({tag, " f rd_data"}, 32'(f_rd_data), 0);
        check({tag, " f count"}, 32'(f_count), 0);
    endtask

    initial begin
        logic [17:0] exp_d;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        rd_en = 1'b0;
        f_wr_en = 1'b0;
        f_wr_data = '0;
        f_rd_en = 1'b0;

        #2;
        check_reset_vals("rst0");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // FWFT: written word is visible next cycle without rd_en
        f_wr_en = 1'b1;
        f_wr_data = 18'h2A5A5;
        tick();
        f_wr_en = 1'b0;
        check("fwft valid", 32'(f_rd_valid), 1);
        check("fwft data", 32'(f_rd_data), 32'h2A5A5);
        check("fwft count", 32'(f_count), 1);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check("fwft pop valid", 32'(f_rd_valid), 0);
        check("fwft pop empty", 32'(f_empty), 1);

        // fill with threshold stepping
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            wr_data = 18'(i);
            tick();
            check($sformatf("fill count %0d", i), 32'(count), 32'(i));
            check($sformatf("fill ae %0d", i), 32'(almost_empty),
                  (i <= 2) ? 1 : 0);
            check($sformatf("fill af %0d", i), 32'(almost_full),
                  (i >= 6) ? 1 : 0);
            check($sformatf("fill empty %0d", i), 32'(empty), 0);
        end
        wr_en = 1'b0;
        check("full after 8", 32'(full), 1);

        wr_en = 1'b1;
        wr_data = 18'h00099;
        tick();
        wr_en = 1'b0;
        check("ovf set", 32'(overflow), 1);
        check("ovf count", 32'(count), 8);
        check("ovf full", 32'(full), 1);

        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            tick();
            check($sformatf("drain data %0d", i), 32'(rd_data), 32'(i));
            check($sformatf("drain valid %0d", i), 32'(rd_valid), 1);
            check($sformatf("drain count %0d", i), 32'(count),
                  32'(8 - i));
        end
        rd_en = 1'b0;
        check("drain empty", 32'(empty), 1);
        tick();
        check("valid pulse end", 32'(rd_valid), 0);
        check("rd_data hold", 32'(rd_data), 8);

        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf set", 32'(underflow), 1);
        check("udf no valid", 32'(rd_valid), 0);
        check("udf count", 32'(count), 0);
        check("ovf sticky", 32'(overflow), 1);

        // count=4 then 10 cycles of simultaneous access across the wrap
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = 18'(32'h10 + i);
            tick();
        end
        check("pre-sim count", 32'(count), 4);
        for (int k = 0; k < 10; k++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            wr_data = 18'(32'h20 + k);
            tick();
            exp_d = (k < 4) ? 18'(32'h10 + k) : 18'(32'h20 + k - 4);
            check($sformatf("sim count %0d", k), 32'(count), 4);
            check($sformatf("sim data %0d", k), 32'(rd_data), 32'(exp_d));
            check($sformatf("sim valid %0d", k), 32'(rd_valid), 1);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        wr_en = 1'b1;
        wr_data = 18'h00030;
        tick();
        wr_en = 1'b0;
        check("pre-flush count", 32'(count), 5);
        check("pre-flush ovf", 32'(overflow), 1);

        // flush beats concurrent read and write
        flush = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 18'h3FFFF;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("flush count", 32'(count), 0);
        check("flush empty", 32'(empty), 1);
        check("flush ovf", 32'(overflow), 0);
        check("flush udf", 32'(underflow), 0);
        check("flush valid", 32'(rd_valid), 0);
        check("flush rd_data hold", 32'(rd_data), 32'h25);

        wr_en = 1'b1;
        wr_data = 18'h00003;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post-flush data", 32'(rd_data), 3);
        check("post-flush empty", 32'(empty), 1);

        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 18'(32'h50 + i);
            f_wr_en = 1'b1;
            f_wr_data = 18'(32'h60 + i);
            tick();
        end
        wr_en = 1'b0;
        f_wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("pre-rst data", 32'(rd_data), 32'h50);
        check("pre-rst f data", 32'(f_rd_data), 32'h60);

        // async reset mid-cycle while a write is pending
        wr_en = 1'b1;
        wr_data = 18'h00077;
        rd_en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst1");
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        check("in-rst count", 32'(count), 0);
        rst_n = 1'b1;
        tick();

        wr_en = 1'b1;
        wr_data = 18'h00044;
        tick();
        wr_en = 1'b0;
        check("post-rst count", 32'(count), 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post-rst data", 32'(rd_data), 32'h44);
        check("post-rst empty", 32'(empty), 1);
        check("post-rst udf", 32'(underflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 18, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of words; a power of two, minimum 4.
REQ-003 SHALL have parameter FWFT, default 0; 0 is standard registered-read mode, 1 is first-word-fall-through mode.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-4, the almost_full threshold in words.
REQ-005 SHALL have parameter AE_LEVEL, default 4, the almost_empty threshold in words.
REQ-006 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-009 SHALL have port wr_en, input, 1 bit: write request.
REQ-010 SHALL have port wr_data, input, WIDTH bits: write word.
REQ-011 SHALL have port rd_en, input, 1 bit: read request (pop).
REQ-012 SHALL have port rd_data, output, WIDTH bits: read word.
REQ-013 SHALL have port rd_valid, output, 1 bit: rd_data holds a valid word.
REQ-014 SHALL have port full / empty, output, 1 bit each: occupancy flags.
REQ-015 SHALL have port almost_full / almost_empty, output, 1 bit each: threshold flags.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-017 SHALL have port overflow / underflow, output, 1 bit each: sticky error flags.

Function
REQ-018 SHALL use read and write pointers $clog2(DEPTH)+1 bits wide; the low bits address storage and the MSB is the wrap bit.
REQ-019 SHALL assert empty when the pointers are equal, and full when the pointer MSBs differ and the low bits are equal.
REQ-020 SHALL compute count as wr_ptr minus rd_ptr, modulo 2^($clog2(DEPTH)+1), registered with the pointers.
REQ-021 SHALL accept a write only when wr_en=1 and full=0; an accepted write stores wr_data at wr_ptr and increments wr_ptr.
REQ-022 SHALL accept a read only when rd_en=1 and empty=0; an accepted read increments rd_ptr.
REQ-023 SHALL not let a simultaneous read make a write acceptable while full; the read is accepted and the write is dropped, with overflow set.
REQ-024 SHALL accept both a read and a write when wr_en=1, rd_en=1, 0<count<DEPTH; count is unchanged.
REQ-025 SHALL treat a write into an empty FIFO with concurrent rd_en as write-only; underflow is set.
REQ-026 SHALL, in FWFT=0 mode, register rd_data = mem[rd_ptr] on an accepted read and pulse rd_valid for exactly the following cycle; rd_data holds its last value otherwise.
REQ-027 SHALL, in FWFT=1 mode, drive rd_data continuously from mem[rd_ptr] with rd_valid = !empty; rd_en pops the displayed word.
REQ-028 SHALL make a written word visible (empty deasserted) in the cycle after the write edge, in both modes.
REQ-029 SHALL assert almost_full when count >= AF_LEVEL and almost_empty when count <= AE_LEVEL.
REQ-030 SHALL set overflow on wr_en while full, and underflow on rd_en while empty; both hold until reset or flush.
REQ-031 SHALL, on flush=1 at a clock edge, zero both pointers, count, rd_valid, overflow and underflow; flush has priority over concurrent reads and writes, which are discarded.
REQ-032 SHALL wrap pointers naturally at 2*DEPTH with no special-case logic.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0, rd_data=0.
REQ-034 SHALL not reset the storage array; its contents are undefined after reset and unobservable until written.
REQ-035 SHALL abort any in-flight operation when reset is asserted mid-operation; the first access after rst_n rises behaves as if the FIFO were empty.

Structure
REQ-036 SHALL take pointer-width and count-width helper constants from the shared dsp package.
REQ-037 SHALL implement storage as one sub-module, sync_fifo_ram: simple dual-port, with synchronous write and read selectable as synchronous or asynchronous; all pointer and flag logic stays in sync_fifo_ext.

Verification (WIDTH=18, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-038 SHALL test fill and drain: write 8 words 0x00001..0x00008 -> full=1 and count=8 after the 8th; 8 reads return the same order, ending with empty=1.
REQ-039 SHALL test overflow and underflow: a 9th write while full -> data dropped, overflow=1, count stays 8; rd_en when empty -> underflow=1.
REQ-040 SHALL test simultaneous access: at count=4, rd_en=wr_en=1 for 10 cycles -> count stays 4, data order preserved across pointer wrap.
REQ-041 SHALL test thresholds: count stepping 0->8 -> almost_empty true at 0..2, almost_full true at 6..8.
REQ-042 SHALL test FWFT=1: a single write of 0x2A5A5 -> the next cycle shows rd_valid=1 and rd_data=0x2A5A5 before any rd_en.
REQ-043 SHALL test flush and reset: flush at count=5 with overflow=1 -> the next cycle shows count=0, empty=1, overflow=0; rst_n pulsed mid-stream -> all REQ-033 values hold immediately and asynchronously.
